// File: rtl/booth_mult_seq.sv
// Sequential 32x32->64 multiplier: radix-2 Booth (signed) / shift-add (unsigned).
// Drives an external CLA adder each RUN cycle. Optional: MULT_ZERO_BYPASS_EN.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_s,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic [WIDTH-1:0] r_m;
    logic             r_q_1;
    logic             r_sgn;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_use_m;
    logic             w_sub;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_sh;
    logic [WIDTH-1:0] w_p_hi_nxt;
    logic [WIDTH-1:0] w_p_lo_nxt;
    logic             w_zero;

`ifdef MULT_ZERO_BYPASS_EN
    assign w_zero = (op_a == '0) || (op_b == '0);
`else
    assign w_zero = 1'b0;
`endif

    // Recode the current multiplier bit(s) into add M / subtract M / add 0.
    always_comb begin
        w_use_m = 1'b0;
        w_sub   = 1'b0;
        if (r_state == S_RUN) begin
            if (r_sgn) begin
                case ({r_p_lo[0], r_q_1})
                    2'b01: w_use_m = 1'b1;
                    2'b10: begin
                        w_use_m = 1'b1;
                        w_sub   = 1'b1;
                    end
                    default: w_use_m = 1'b0;
                endcase
            end else begin
                w_use_m = r_p_lo[0];
            end
        end
    end

    assign w_add_a = (r_state == S_RUN) ? r_p_hi : '0;
    assign w_add_b = w_use_m ? r_m : '0;

    // Signed mode needs the true 33rd sum bit, not the carry-out.
    assign w_sh = r_sgn
        ? (w_add_a[WIDTH-1] ^ (w_add_b[WIDTH-1] ^ w_sub) ^ add_cout)
        : add_cout;

    assign w_p_hi_nxt = {w_sh, add_sum[WIDTH-1:1]};
    assign w_p_lo_nxt = {add_sum[0], r_p_lo[WIDTH-1:1]};

    assign add_a   = w_add_a;
    assign add_b   = w_add_b;
    assign add_cin = w_sub;
    assign add_s   = r_sgn;
    assign busy    = r_busy;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;

    // Control FSM plus partial-product datapath and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_m     <= '0;
            r_q_1   <= 1'b0;
            r_sgn   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_zero) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_hi    <= '0;
                        r_lo    <= '0;
                    end else if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_p_hi  <= '0;
                        r_p_lo  <= op_b;
                        r_q_1   <= 1'b0;
                        r_m     <= op_a;
                        r_sgn   <= signed_op;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_p_hi  <= w_p_hi_nxt;
                    r_p_lo  <= w_p_lo_nxt;
                    r_q_1   <= r_p_lo[0];
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_p_hi_nxt;
                        r_lo    <= w_p_lo_nxt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq with a behavioural CLA adder attached.
// Expected products come from plain 64-bit arithmetic.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic        add_s;
    logic [31:0] add_sum;
    logic        add_cout;

    booth_mult_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .signed_op(signed_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Attached adder: cin=1 inverts in2 and adds one.
    logic [32:0] adder_res;
    assign adder_res = {1'b0, add_a}
                     + {1'b0, (add_cin ? ~add_b : add_b)}
                     + {32'd0, add_cin};
    assign add_sum  = adder_res[31:0];
    assign add_cout = adder_res[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          d0       = 0;
    logic [63:0] last_p   = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_mul(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic s);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = s ? {{32{a[31]}}, a} : {32'd0, a};
        y = s ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    // Monitor: pop and compare every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo}, {32'd0, e.lo});
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                end
                done_cnt++;
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit push);
        exp_t        e;
        logic [63:0] p;
        d0 = done_cnt;
        @(negedge clk);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_op = s;
        if (push) begin
            p    = model_mul(a, b, s);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.cyc  = cyc + 33;
            e.busy = 32;
`ifdef MULT_ZERO_BYPASS_EN
            if (a == 32'd0 || b == 32'd0) begin
                e.cyc  = cyc + 1;
                e.busy = 0;
            end
`endif
            sb.push_back(e);
            last_p = p;
        end
        @(negedge clk);
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        signed_op = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
        #1;
        if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("hold", {hi, lo}, last_p);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic s);
        issue(a, b, s, 1'b1);
        wait_done();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_add_a", {32'd0, add_a}, 64'd0);
        chk("rst_add_b", {32'd0, add_b}, 64'd0);
        chk("rst_add_cin", {63'd0, add_cin}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(32'd3, 32'd10, 1'b0);
        chk("u3x10", {hi, lo}, 64'h0000_0000_0000_001E);
        run(32'hFFFF_FFFF, 32'd5, 1'b1);
        chk("s_m1x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
        run(32'hFFFF_FFFF, 32'd5, 1'b0);
        chk("u_m1x5", {hi, lo}, 64'h0000_0004_FFFF_FFFB);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("u_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run(32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("s_min", {hi, lo}, 64'h4000_0000_0000_0000);

        // Second start while busy must be ignored.
        issue(32'd7, 32'd6, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        start     = 1'b1;
        op_a      = 32'd2;
        op_b      = 32'd2;
        @(negedge clk);
        start     = 1'b0;
        wait_done();
        chk("ovl_lo", {32'd0, lo}, 64'h2A);
        repeat (40) @(negedge clk);
        chk("one_done", 64'(done_cnt - d0), 64'd1);

        // Asynchronous abort mid-operation.
        issue(32'hDEAD_BEEF, 32'h0001_2345, 1'b1, 1'b1);
        repeat (13) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        sb.delete();
        busy_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(32'h0000_1234, 32'h0000_5678, 1'b0);

        run(32'd0, 32'h1234_5678, 1'b0);
        chk("zero", {hi, lo}, 64'd0);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'd0;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            run(a, b, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential 32x32 -> 64-bit multiplier for the EX stage; produces HI/LO results for MULT/MULTU.
- Sits directly upstream of the team's combinational 32-bit CLA adder. Each cycle it drives that adder's operand, carry-in and sign inputs, then consumes its sum and carry-out.
- Uses radix-2 Booth recoding in signed mode and plain shift-add in unsigned mode.
- Start/busy/done handshake toward the pipeline control.

Parameters:
- WIDTH, 32, operand width. Must equal the attached adder width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- signed_op  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- op_a  in  32  multiplicand M; sampled with start.
- op_b  in  32  multiplier Q; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; hi/lo valid from this cycle.
- hi  out  32  upper product word.
- lo  out  32  lower product word.
- add_a  out  32  to adder in1: partial product P_hi.
- add_b  out  32  to adder in2: M or 0.
- add_cin  out  1  to adder cin; 1 = subtract (adder inverts in2 and adds 1).
- add_s  out  1  to adder signed-select; equals latched signed_op.
- add_sum  in  32  from adder sum; combinational, same cycle.
- add_cout  in  1  from adder cout; same cycle.

Behaviour:
- Reset: clk, rst_n as decided; reset is asynchronous and active-low.
  - State goes to IDLE.
  - busy=0, done=0, hi=0, lo=0, internal P_hi/P_lo/q_1/count=0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - add_a=0, add_b=0, add_cin=0.
  - On start: P_hi<=0, P_lo<=op_b, q_1<=0, M<=op_a, sgn<=signed_op, count<=0, go to RUN.
- RUN (exactly 32 cycles, busy=1): recode each cycle.
  - Unsigned: P_lo[0]=1 -> add M (add_b=M, cin=0); else add 0 (add_b=0, cin=0).
  - Signed, {P_lo[0],q_1}: 01 -> add M (cin=0); 10 -> subtract M (add_b=M, cin=1); 00/11 -> add_b=0, cin=0.
  - Shift-in bit sh:
    - Unsigned: sh = add_cout.
    - Signed: sh = add_a[31] ^ (add_b[31]^add_cin) ^ add_cout, i.e. the true 33rd sum bit.
    - sh never uses the adder ov output.
  - Update: P_hi<={sh, add_sum[31:1]}, P_lo<={add_sum[0], P_lo[31:1]}, q_1<=P_lo[0], count<=count+1.
  - After the 32nd iteration (count==31) go to DONE.
- DONE (one cycle):
  - done=1, busy=0; hi=P_hi, lo=P_lo registered.
  - Go to IDLE.
  - start in DONE is ignored.
- Latency: start sampled at edge 0 -> busy high cycles 1..32 -> done high cycle 33.
- hi/lo hold their values until the next completed operation.
- start while busy or in DONE is ignored. Operands are latched, so op_a/op_b may change freely after start.
- hi/lo change only at entry to DONE. They are never partially updated.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, start with op_a==0 or op_b==0 skips RUN.
  - Next state is DONE with hi=0, lo=0; done is high in cycle 1 after start.
  - busy never asserts; the adder is not exercised.
- Undefined: every operation takes the full 32-iteration path (done at cycle 33).

Test Plan:
- Unsigned 3 x 10 (start at edge 0) -> busy cycles 1..32, done cycle 33, hi=0x00000000, lo=0x0000001E.
- Signed 0xFFFFFFFF x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB. Unsigned same operands -> hi=0x00000004, lo=0xFFFFFFFB.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Start 7 x 6, then pulse start with 2 x 2 at cycle 10 -> second start ignored, result lo=0x0000002A, exactly one done pulse.
- Drop rst_n at cycle 15 of an operation -> busy/done/hi/lo=0 immediately (async), no done. A new start after release gives the correct product at +33.
- With MULT_ZERO_BYPASS_EN: 0 x 0x12345678 -> done cycle 1, hi=lo=0, busy never high. Without the macro: done at cycle 33, hi=lo=0.
